board_scanner: RTL
==================

Name: board_scanner

Overview:
- Initiator side of the cell-render interface: walks the board storage RAM cell by cell and reads each cell byte.
- Presents each non-empty cell (address + content) to the cell renderer, then waits for the renderer's done before advancing.
- Sits between board storage (read port) and the cell renderer that drives the VGA adapter. One pass equals one frame redraw.

Parameters:
- COLS, 10, board columns; address[3:0] = column, 0..COLS-1.
- ROWS, 10, board rows; address[7:4] = row, 0..ROWS-1.
- RAM_LAT, 1, cycles from ram_addr change to valid ram_q (1..3).
- AUTO_RESTART, 0, when 1 a new frame starts immediately after frame_done without start.

Ports:
- clock  in  1  system clock, 50 MHz, all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  begin one frame scan; sampled only in IDLE.
- ram_addr  out  8  storage read address {row[3:0], col[3:0]}.
- ram_q  in  8  storage read data (cell byte: bit7 wall, bit6 tank1, bit5 tank2, bit4 projectile, bits3:2 direction).
- cell_addr  out  8  cell address presented to renderer.
- cell_data  out  8  cell byte presented to renderer.
- draw_req  out  1  cell_addr/cell_data valid; renderer must draw.
- draw_done  in  1  renderer finished current cell.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse at end of pass.
- drawn_count  out  8  number of non-empty cells drawn in last completed frame.

Behaviour:
- Reset (async, resetn=0) forces:
  - state=IDLE; row=col=0; ram_addr=0x00; cell_addr=0x00; cell_data=0x00.
  - draw_req=0; busy=0; frame_done=0; drawn_count=0; internal count=0.
- Reset mid-frame aborts the pass immediately. There is no resume; the next frame starts from cell 0x00.
- ram_addr is registered and always equals {row,col}.
- FSM states: IDLE, READ, FETCH, REQ, ADVANCE, FINISH.
- IDLE:
  - busy=0. On start=1: row=col=0, count=0, go to READ.
  - start is ignored in every other state.
- READ: wait RAM_LAT cycles (internal wait counter), then go to FETCH.
- FETCH: latch cell_data<=ram_q and cell_addr<=ram_addr.
  - If ram_q==0x00 (empty): go to ADVANCE, no request.
  - Else: go to REQ and assert draw_req on the next cycle.
- REQ:
  - draw_req=1; cell_addr and cell_data held stable.
  - draw_done is ignored in the first REQ cycle, because the renderer needs one cycle to clear a stale done.
  - From the second REQ cycle, draw_done=1 triggers: draw_req<=0, count+=1, go to ADVANCE.
  - No timeout; draw_req stays high indefinitely until done.
- ADVANCE:
  - If col==COLS-1: col<=0, then row<=row+1, or go to FINISH if row==ROWS-1.
  - Else col<=col+1.
  - Go to READ otherwise.
- FINISH:
  - frame_done=1 for exactly one cycle; drawn_count<=count.
  - Go to IDLE, or to READ with row=col=0, count=0 if AUTO_RESTART=1.
- draw_done high while draw_req=0 has no effect.
- start held high continuously with AUTO_RESTART=0 starts a new frame on the cycle after returning to IDLE.
- Width rules:
  - Column/row counters are 4 bits; addresses with col>=COLS or row>=ROWS are never issued.
  - count is 8 bits; max 100 with defaults, so no overflow.
- Cycle cost per cell with RAM_LAT=1:
  - empty cell = 3 cycles (READ, FETCH, ADVANCE);
  - drawn cell = 4 + renderer latency.

Test Plan:
- All-zero RAM, pulse start → no draw_req ever. frame_done pulses once after 300 cycles (+IDLE exit); drawn_count=0; last ram_addr=0x99.
- Cells 0x00=0x40, 0x15=0x80, 0x99=0x14; renderer returns done 5 cycles after req → exactly 3 draw_req handshakes with cell_addr/data (0x00,0x40), (0x15,0x80), (0x99,0x14) in order; drawn_count=3.
- draw_done tied high constantly, one non-empty cell → draw_req lasts exactly 2 cycles (first-cycle done ignored); data stable throughout.
- resetn pulled low while draw_req=1 on cell 0x23 → draw_req and busy drop asynchronously; ram_addr=0x00. A new start rescans from 0x00; drawn_count=0 until FINISH.
- start pulsed while busy → ignored; only one frame_done per frame. With AUTO_RESTART=1 and a single start, frame_done pulses repeatedly with identical spacing.
- RAM_LAT=3 with RAM model delaying data 3 cycles → cell_data always matches the addressed cell; no off-by-one at column wrap 0x09→0x10.

Source files
------------

// File: rtl/board_scanner.sv
// board_scanner: walks the board storage RAM cell by cell, one pass per frame
// redraw, and hands every non-empty cell (address + byte) to the cell renderer
// with a req/done handshake.
module board_scanner #(
  parameter int COLS         = 10,
  parameter int ROWS         = 10,
  parameter int RAM_LAT      = 1,
  parameter int AUTO_RESTART = 0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_q,
  output logic [7:0] cell_addr,
  output logic [7:0] cell_data,
  output logic       draw_req,
  input  logic       draw_done,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] drawn_count
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FETCH,
    REQ,
    ADVANCE,
    FINISH
  } state_t;

  state_t     r_state;
  state_t     w_nextState;

  logic [3:0] r_row;
  logic [3:0] r_col;
  logic [1:0] r_waitCnt;
  logic       r_reqFirst;
  logic [7:0] r_count;
  logic [7:0] r_cellAddr;
  logic [7:0] r_cellData;
  logic [7:0] r_drawnCount;

  logic       w_lastCol;
  logic       w_lastRow;
  logic       w_waitDone;
  logic       w_drawAccept;
  logic       w_autoRestart;

  assign w_lastCol     = (r_col == 4'(COLS - 1));
  assign w_lastRow     = (r_row == 4'(ROWS - 1));
  assign w_waitDone    = (r_waitCnt == 2'(RAM_LAT - 1));
  // The renderer may still be showing a stale done in the first REQ cycle,
  // so a done only counts once that first cycle has passed.
  assign w_drawAccept  = (r_state == REQ) && !r_reqFirst && draw_done;
  assign w_autoRestart = (AUTO_RESTART != 0);

  assign ram_addr    = {r_row, r_col};
  assign cell_addr   = r_cellAddr;
  assign cell_data   = r_cellData;
  assign drawn_count = r_drawnCount;

  // State register; reset aborts any pass in progress.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the handshake/status outputs that follow the state.
  always_comb begin
    w_nextState = r_state;
    draw_req    = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_nextState = READ;
        end
      end
      READ: begin
        if (w_waitDone) begin
          w_nextState = FETCH;
        end
      end
      FETCH: begin
        w_nextState = (ram_q == 8'h00) ? ADVANCE : REQ;
      end
      REQ: begin
        draw_req = 1'b1;
        if (w_drawAccept) begin
          w_nextState = ADVANCE;
        end
      end
      ADVANCE: begin
        w_nextState = (w_lastCol && w_lastRow) ? FINISH : READ;
      end
      FINISH: begin
        frame_done  = 1'b1;
        w_nextState = w_autoRestart ? READ : IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Scan position, RAM wait counter, latched cell and per-frame draw count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_row        <= 4'd0;
      r_col        <= 4'd0;
      r_waitCnt    <= 2'd0;
      r_reqFirst   <= 1'b0;
      r_count      <= 8'd0;
      r_cellAddr   <= 8'h00;
      r_cellData   <= 8'h00;
      r_drawnCount <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_row     <= 4'd0;
            r_col     <= 4'd0;
            r_count   <= 8'd0;
            r_waitCnt <= 2'd0;
          end
        end
        READ: begin
          if (!w_waitDone) begin
            r_waitCnt <= r_waitCnt + 2'd1;
          end
        end
        FETCH: begin
          r_cellData <= ram_q;
          r_cellAddr <= {r_row, r_col};
          r_reqFirst <= 1'b1;
        end
        REQ: begin
          r_reqFirst <= 1'b0;
          if (w_drawAccept) begin
            r_count <= r_count + 8'd1;
          end
        end
        ADVANCE: begin
          r_waitCnt <= 2'd0;
          if (w_lastCol) begin
            // On the very last cell the position is left at the final address.
            if (!w_lastRow) begin
              r_col <= 4'd0;
              r_row <= r_row + 4'd1;
            end
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
        FINISH: begin
          r_drawnCount <= r_count;
          if (w_autoRestart) begin
            r_row     <= 4'd0;
            r_col     <= 4'd0;
            r_count   <= 8'd0;
            r_waitCnt <= 2'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
